// File: rtl/spongent_pkg.sv
// Shared definitions for the SPONGENT round controller: FSM encoding,
// default geometry of the round-constant LFSR, and its feedback taps.
package spongent_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_LFSR_W     = 6;
  localparam int DEF_LFSR_INIT  = 'h05;
  localparam int DEF_NUM_ROUNDS = 45;

  // Feedback taps as offsets from LFSR_W: bit[LFSR_W-1] ^ bit[LFSR_W-2]
  localparam int FB_TAP_A_OFS = 1;
  localparam int FB_TAP_B_OFS = 2;

endpackage

// File: rtl/spongent_rc_rev.sv
// Bit reversal of a 16-bit word (out[15-k] = in[k]); pure wiring.
module spongent_rc_rev (
  input  logic [15:0] i_d,
  output logic [15:0] o_d
);

  for (genvar k = 0; k < 16; k++) begin : g_rev
    assign o_d[15-k] = i_d[k];
  end

endmodule

// File: rtl/spongent_round_ctrl.sv
// SPONGENT permutation round controller: sequences NUM_ROUNDS rounds,
// stepping an LFSR round counter each time the datapath accepts a round,
// and presents the round constants rc_lo / rc_hi.
// Optional feature macro: SPONGENT_ROUND_ABORT_EN (adds the abort input).
module spongent_round_ctrl
  import spongent_pkg::*;
#(
  parameter int LFSR_W     = DEF_LFSR_W,
  parameter int LFSR_INIT  = DEF_LFSR_INIT,
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dp_ready,
`ifdef SPONGENT_ROUND_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        round_en,
  output logic [15:0] rc_lo,
  output logic [15:0] rc_hi,
  output logic [7:0]  round_idx,
  output logic        last_round,
  output logic        done
);

  localparam logic [LFSR_W-1:0] LP_INIT = LFSR_W'(LFSR_INIT);
  localparam logic [7:0]        LP_LAST = 8'(NUM_ROUNDS - 1);

  state_t              r_state, w_state_nxt;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [7:0]          r_idx;
  logic                w_run, w_abort, w_adv, w_fb, w_is_last;
  logic [LFSR_W-1:0]   w_lfsr_nxt;
  logic [15:0]         w_lfsr16, w_rev;

`ifdef SPONGENT_ROUND_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_run      = (r_state == ST_RUN);
  assign w_is_last  = (r_idx == LP_LAST);
  // Abort wins over dp_ready so an aborted round never advances the LFSR
  assign w_adv      = w_run && dp_ready && !w_abort;
  assign w_fb       = r_lfsr[LFSR_W-FB_TAP_A_OFS] ^ r_lfsr[LFSR_W-FB_TAP_B_OFS];
  assign w_lfsr_nxt = {r_lfsr[LFSR_W-2:0], w_fb};
  assign w_lfsr16   = 16'(r_lfsr);

  // High constant is the reversed LFSR; upper input byte is zero so [7:0] stay 0
  spongent_rc_rev u_rev (
    .i_d (w_lfsr16),
    .o_d (w_rev)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_abort)                    w_state_nxt = ST_IDLE;
        else if (dp_ready && w_is_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // LFSR and round index: load on accepted start, step on each accepted round
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= '0;
      r_idx  <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_lfsr <= LP_INIT;
      r_idx  <= '0;
    end else if (w_adv) begin
      r_lfsr <= w_lfsr_nxt;
      r_idx  <= r_idx + 8'd1;
    end
  end

  assign busy       = w_run;
  assign round_en   = w_run;
  assign rc_lo      = w_run ? w_lfsr16 : 16'h0;
  assign rc_hi      = w_run ? w_rev    : 16'h0;
  assign round_idx  = w_run ? r_idx    : 8'h0;
  assign last_round = w_run && w_is_last;
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_spongent_round_ctrl.sv
// Self-checking bench for spongent_round_ctrl (default parameters).
module tb_spongent_round_ctrl;

  localparam int NR   = 45;
  localparam int W    = 6;
  localparam int INIT = 'h05;

  logic        clk = 1'b0;
  logic        rst, start, dp_ready;
  logic        busy, round_en, last_round, done;
  logic [15:0] rc_lo, rc_hi;
  logic [7:0]  round_idx;
`ifdef SPONGENT_ROUND_ABORT_EN
  logic        abort;
`endif

  always #5 clk = ~clk;

  spongent_round_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dp_ready   (dp_ready),
`ifdef SPONGENT_ROUND_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .round_en   (round_en),
    .rc_lo      (rc_lo),
    .rc_hi      (rc_hi),
    .round_idx  (round_idx),
    .last_round (last_round),
    .done       (done)
  );

  int checks = 0, failures = 0;

  // Reference model: phase 0=idle 1=run 2=done, plus current round number.
  int m_mode = 0, m_idx = 0;
  int seq_lo[NR];
  int seq_hi[NR];

  function automatic int lfsr_next(int l);
    return ((l << 1) & ((1 << W) - 1)) | (((l >> (W-1)) ^ (l >> (W-2))) & 1);
  endfunction

  function automatic int rev_hi(int l);
    int h = 0;
    for (int k = 0; k < 8; k++) if (((l >> k) & 1) != 0) h |= (1 << (15-k));
    return h;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_update();
    logic ab;
    ab = 1'b0;
`ifdef SPONGENT_ROUND_ABORT_EN
    ab = abort;
`endif
    if (rst) begin
      m_mode = 0; m_idx = 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_idx = 0; end
        1: if (ab) m_mode = 0;
           else if (dp_ready) begin
             if (m_idx == NR-1) m_mode = 2;
             else m_idx++;
           end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic model_cmp();
    logic run;
    run = (m_mode == 1);
    chk("busy",       32'(busy),       32'(run));
    chk("round_en",   32'(round_en),   32'(run));
    chk("rc_lo",      32'(rc_lo),      run ? seq_lo[m_idx] : 0);
    chk("rc_hi",      32'(rc_hi),      run ? seq_hi[m_idx] : 0);
    chk("round_idx",  32'(round_idx),  run ? m_idx : 0);
    chk("last_round", 32'(last_round), 32'(run && m_idx == NR-1));
    chk("done",       32'(done),       32'(m_mode == 2));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic drain();
    int n = 0;
    while (m_mode != 0 && n < 200) begin dp_ready = 1'b1; step(); n++; end
    chk("drain_timeout", 32'(m_mode != 0), 32'd0);
  endtask

  typedef struct {
    logic        st;
    logic        dp;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [7:0]  idx;
  } vec_t;

  vec_t tv[9];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ren, lastcnt, lastidx, done_at, dcnt;
    int l;

    l = INIT;
    for (int i = 0; i < NR; i++) begin
      seq_lo[i] = l; seq_hi[i] = rev_hi(l); l = lfsr_next(l);
    end

    // Rounds 0..3 with a 5-cycle stall on round 2
    tv[0] = '{1'b1, 1'b1, 16'h0005, 16'hA000, 8'd0};
    tv[1] = '{1'b0, 1'b1, 16'h000A, 16'h5000, 8'd1};
    tv[2] = '{1'b0, 1'b1, 16'h0014, 16'h2800, 8'd2};
    for (int i = 3; i < 8; i++) tv[i] = '{1'b0, 1'b0, 16'h0014, 16'h2800, 8'd2};
    tv[8] = '{1'b0, 1'b1, 16'h0029, 16'h9400, 8'd3};

    rst = 1'b1; start = 1'b0; dp_ready = 1'b0;
`ifdef SPONGENT_ROUND_ABORT_EN
    abort = 1'b0;
`endif
    #3;
    model_cmp();
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      start = tv[i].st; dp_ready = tv[i].dp;
      step();
      chk($sformatf("tv%0d_busy", i),  32'(busy),      32'd1);
      chk($sformatf("tv%0d_lo", i),    32'(rc_lo),     32'(tv[i].lo));
      chk($sformatf("tv%0d_hi", i),    32'(rc_hi),     32'(tv[i].hi));
      chk($sformatf("tv%0d_idx", i),   32'(round_idx), 32'(tv[i].idx));
    end
    start = 1'b0;
    drain();
    step();

    // Full run: latency, round_en count, single last_round
    start = 1'b1; dp_ready = 1'b1;
    n = 0; ren = 0; lastcnt = 0; lastidx = -1; done_at = 0;
    while (done_at == 0 && n < 100) begin
      step(); start = 1'b0; n++;
      if (round_en) ren++;
      if (last_round) begin lastcnt++; lastidx = round_idx; end
      if (done) done_at = n;
    end
    chk("done_latency",   done_at, NR + 1);
    chk("round_en_count", ren,     NR);
    chk("last_cnt",       lastcnt, 1);
    chk("last_idx",       lastidx, NR - 1);
    step();
    chk("busy_after",     32'(busy), 32'd0);

    // Start held high: restart accepted in the idle cycle after done
    start = 1'b1; dp_ready = 1'b1;
    n = 0; ren = 0; dcnt = 0;
    while (dcnt == 0 && n < 100) begin
      step(); n++;
      if (round_en) ren++;
      if (done) dcnt++;
    end
    chk("held_first_rounds", ren, NR);
    step();
    chk("held_idle_gap", 32'(busy), 32'd0);
    step();
    chk("held_rerun_busy", 32'(busy),  32'd1);
    chk("held_rerun_lo",   32'(rc_lo), 32'h0005);
    start = 1'b0;
    drain();
    step();

    // Asynchronous reset at round 10
    start = 1'b1; dp_ready = 1'b1;
    step(); start = 1'b0;
    n = 0;
    while (m_idx < 10 && n < 50) begin step(); n++; end
    chk("rst_reach_r10", 32'(round_idx), 32'd10);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ren",   32'(round_en),  32'd0);
    chk("rst_lo",    32'(rc_lo),     32'd0);
    chk("rst_hi",    32'(rc_hi),     32'd0);
    chk("rst_idx",   32'(round_idx), 32'd0);
    chk("rst_last",  32'(last_round),32'd0);
    chk("rst_done",  32'(done),      32'd0);
    step();
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin step(); if (done) dcnt++; end
    chk("rst_no_done", dcnt, 0);
    start = 1'b1;
    step(); start = 1'b0;
    chk("rst_fresh_lo", 32'(rc_lo), 32'h0005);
    drain();
    step();

`ifdef SPONGENT_ROUND_ABORT_EN
    // Abort at round 7
    start = 1'b1; dp_ready = 1'b1;
    step(); start = 1'b0;
    n = 0;
    while (m_idx < 7 && n < 50) begin step(); n++; end
    chk("abort_at_r7", 32'(round_idx), 32'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    step();
    chk("abort_no_done", 32'(done), 32'd0);
    start = 1'b1;
    step(); start = 1'b0;
    chk("abort_reload_lo", 32'(rc_lo), 32'h0005);
    drain();
    step();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      dp_ready = ($urandom_range(0, 3) != 0);
`ifdef SPONGENT_ROUND_ABORT_EN
      abort    = ($urandom_range(0, 39) == 0);
`endif
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
